positadd_issue_stream: RTL and testbench
========================================

POSITADD_ISSUE_STREAM -- requirements
Module: positadd_issue_stream

Interface
REQ-001 SHALL have parameter LAT, default 8, meaning fixed start-to-done latency of the attached 32-bit posit adder in cycles.
REQ-002 SHALL have parameter DEPTH, default 16, meaning result FIFO entries, a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_a  input  32  first posit operand.
REQ-008 in_b  input  32  second posit operand.
REQ-009 add_start  output  1  issue pulse to the adder start input.
REQ-010 add_in1  output  32  adder operand 1.
REQ-011 add_in2  output  32  adder operand 2.
REQ-012 add_result  input  32  adder result.
REQ-013 add_inf  input  1  adder infinity flag.
REQ-014 add_zero  input  1  adder zero flag.
REQ-015 add_done  input  1  adder result-valid pulse.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  downstream accepts the result.
REQ-018 out_data  output  32  result posit.
REQ-019 out_inf  output  1  infinity flag for out_data.
REQ-020 out_zero  output  1  zero flag for out_data.
REQ-021 err  output  1  sticky flag: add_done arrived with no request outstanding.

Function
REQ-022 The block SHALL keep an occupancy count, equal to inflight plus fifo_count, with the following rules.
- Issue (in_valid and in_ready) adds 1 to both inflight and occupancy.
- An accepted add_done moves one entry from inflight into the FIFO; occupancy is unchanged.
- A pop (out_valid and out_ready) subtracts 1 from occupancy.
- Simultaneous issue, done and pop SHALL all apply in the same cycle.
REQ-023 in_ready SHALL be 1 exactly when registered occupancy is below DEPTH and the block is not draining; it SHALL NOT depend on out_ready.
REQ-024 add_start SHALL equal (in_valid and in_ready) combinationally; add_in1 and add_in2 SHALL equal in_a and in_b combinationally.
REQ-025 On an accepted add_done, the block SHALL write {add_result, add_inf, add_zero} to the FIFO write pointer in that cycle; the adder has no backpressure, so an accepted done SHALL never be dropped.
REQ-026 out_valid SHALL be 1 when fifo_count is above 0; out_data, out_inf and out_zero SHALL come from the read-pointer entry, in issue order.
REQ-027 Latency SHALL be as follows.
- An operand pair accepted in cycle N SHALL appear on out_valid in cycle N+LAT+1.
- With DEPTH at least LAT+1 and out_ready held at 1, the block SHALL accept one pair per cycle.
REQ-028 The FIFO pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-029 A pop of an empty FIFO and a push into a full FIFO SHALL be impossible by construction, because of the occupancy rule.
REQ-030 add_done with inflight equal to 0 outside the drain window SHALL be ignored and SHALL set err, which stays set until reset.
REQ-031 The state machine SHALL have states DRAIN and RUN.
- DRAIN: in_ready is 0, and add_done is discarded without setting err, because the adder pipeline is not reset.
- DRAIN counts LAT cycles, then moves to RUN.
- RUN is normal operation; there is no transition back to DRAIN except by reset.

Reset
REQ-032 While reset_n is 0, the block SHALL asynchronously clear the following:
- occupancy, inflight, the pointers and err;
- the drain counter, to LAT;
- the state, to DRAIN;
- out_valid, in_ready and add_start, to 0;
- out_data, out_inf and out_zero, to 0.
REQ-033 Reset during operation SHALL discard all FIFO contents and in-flight requests; done pulses from the old pipeline SHALL be absorbed by the DRAIN state.
REQ-034 The first in_ready=1 after release SHALL occur LAT cycles after the first rising clk edge with reset_n at 1.

Configuration
REQ-035 With POSITADD_ISSUE_STREAM_STATS_EN defined, the block SHALL add the following outputs, each cleared by reset:
- stat_inf_cnt (16 bits): increments on each popped result with out_inf at 1;
- stat_zero_cnt (16 bits): increments on each popped result with out_zero at 1;
- both counters saturate at 16'hFFFF.
REQ-036 Without POSITADD_ISSUE_STREAM_STATS_EN, those ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-037 Single pair: after drain, send in_a=0x40000000, in_b=0x40000000 with the adder model returning 0x48000000 at LAT=8 -> out_valid rises 9 cycles after the handshake, out_data=0x48000000, out_inf=0, out_zero=0.
REQ-038 Full throughput: 32 back-to-back pairs with out_ready=1 -> in_ready never drops, and 32 results come out in order with no gaps after the first.
REQ-039 Backpressure: out_ready=0 while in_valid=1 -> exactly 16 pairs are accepted, then in_ready=0; raising out_ready for 1 cycle -> one pop and one further accept.
REQ-040 Spurious done: in RUN with inflight=0, pulse add_done -> err=1, fifo_count unchanged, err stays 1.
REQ-041 Reset mid-stream: 5 pairs in flight, then assert reset_n=0 for 1 cycle -> out_valid=0, err stays 0 while 5 stale dones arrive, and in_ready=1 after 8 cycles.
REQ-042 Stats (macro defined): pop 3 results with out_inf=1 and 2 with out_zero=1 -> stat_inf_cnt=3, stat_zero_cnt=2.

Source files
------------

// File: rtl/positadd_issue_stream.sv
// positadd_issue_stream
//   Issue/collect wrapper around a fixed-latency 32-bit posit adder. Operand
//   pairs are issued straight to the adder. Results come back LAT cycles later
//   and land in a result FIFO, which drains in issue order. Every issued
//   request reserves a FIFO slot: occupancy = inflight + fifo_count, and
//   issue is allowed only while occupancy < DEPTH. Because the adder cannot be
//   stalled, this reservation means an accepted done always has a slot.
//
//   After reset the adder pipeline may still hold stale requests. The block
//   spends LAT cycles in DRAIN and discards any done pulses during that time.
//
// Parameters
//   LAT    adder start-to-done latency in cycles (>= 1)
//   DEPTH  result FIFO entries (power of two, >= 2)
//
// Ports
//   clk, reset_n                       clock, async active-low reset
//   in_valid/in_ready/in_a/in_b        operand pair stream in
//   add_start/add_in1/add_in2          adder issue side
//   add_result/add_inf/add_zero/add_done  adder completion side
//   out_valid/out_ready/out_data/out_inf/out_zero  result stream out
//   err                                sticky: done seen with nothing in flight
//   stat_inf_cnt/stat_zero_cnt         popped-result counters, saturating
//                                      (only with POSITADD_ISSUE_STREAM_STATS_EN)
//
// Build option
//   POSITADD_ISSUE_STREAM_STATS_EN   adds stat_inf_cnt / stat_zero_cnt
//
// state | meaning
// ------+-----------------------------------------------------------------
// DRAIN | in_ready low for LAT cycles; stale adder dones are discarded
// RUN   | normal issue/collect; left only through reset

module positadd_issue_stream #(
  parameter int LAT   = 8,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        add_start,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  input  logic [31:0] add_result,
  input  logic        add_inf,
  input  logic        add_zero,
  input  logic        add_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inf,
  output logic        out_zero,
  output logic        err
`ifdef POSITADD_ISSUE_STREAM_STATS_EN
  ,
  output logic [15:0] stat_inf_cnt,
  output logic [15:0] stat_zero_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic {
    DRAIN = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   drain_q;

  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic            err_q, err_d;

  // Each entry: {result[31:0], inf, zero}
  logic [33:0]     mem_q [DEPTH];

  logic            run;
  logic            issue;
  logic            pop;
  logic            done_acc;
  logic            done_spur;

  assign run       = (state_q == RUN);
  assign in_ready  = run && (occ_q < CW'(DEPTH));
  assign issue     = in_valid && in_ready;
  assign add_start = issue;
  assign add_in1   = in_a;
  assign add_in2   = in_b;

  assign out_valid = (fcnt_q != '0);
  assign pop       = out_valid && out_ready;

  // Dones in DRAIN belong to the pre-reset pipeline and are silently dropped.
  assign done_acc  = add_done && run && (infl_q != '0);
  assign done_spur = add_done && run && (infl_q == '0);

  // The memory is not reset, so the read side is gated to give zeros when empty.
  assign out_data  = out_valid ? mem_q[rd_q][33:2] : 32'h0;
  assign out_inf   = out_valid ? mem_q[rd_q][1]    : 1'b0;
  assign out_zero  = out_valid ? mem_q[rd_q][0]    : 1'b0;
  assign err       = err_q;

  always_comb begin
    occ_d  = occ_q  + CW'(issue)    - CW'(pop);
    infl_d = infl_q + CW'(issue)    - CW'(done_acc);
    fcnt_d = fcnt_q + CW'(done_acc) - CW'(pop);
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_d   = wr_q + PW'(done_acc);
    rd_d   = rd_q + PW'(pop);
    err_d  = err_q | done_spur;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DRAIN;
      drain_q <= DW'(LAT);
    end else begin
      case (state_q)
        DRAIN: begin
          if (drain_q == '0) state_q <= RUN;
          else               drain_q <= drain_q - DW'(1);
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= DRAIN;
          drain_q <= DW'(LAT);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q  <= '0;
      infl_q <= '0;
      fcnt_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      fcnt_q <= fcnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (done_acc) mem_q[wr_q] <= {add_result, add_inf, add_zero};
  end

`ifdef POSITADD_ISSUE_STREAM_STATS_EN
  logic [15:0] stat_inf_q, stat_zero_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_inf_q  <= '0;
      stat_zero_q <= '0;
    end else begin
      if (pop && out_inf && (stat_inf_q != 16'hFFFF))   stat_inf_q  <= stat_inf_q + 16'd1;
      if (pop && out_zero && (stat_zero_q != 16'hFFFF)) stat_zero_q <= stat_zero_q + 16'd1;
    end
  end

  assign stat_inf_cnt  = stat_inf_q;
  assign stat_zero_cnt = stat_zero_q;
`endif

endmodule

// File: tb/tb_positadd_issue_stream.sv
`timescale 1ns/1ps
module tb_positadd_issue_stream;

  localparam int LAT   = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic        in_ready, add_start, add_inf, add_zero, add_done;
  logic [31:0] add_in1, add_in2, add_result;
  logic        out_valid, out_inf, out_zero, err;
  logic [31:0] out_data;
`ifdef POSITADD_ISSUE_STREAM_STATS_EN
  logic [15:0] stat_inf_cnt, stat_zero_cnt;
`endif

  positadd_issue_stream #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inf(out_inf), .out_zero(out_zero), .err(err)
`ifdef POSITADD_ISSUE_STREAM_STATS_EN
    , .stat_inf_cnt(stat_inf_cnt), .stat_zero_cnt(stat_zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in adder arithmetic: 1.0 + 1.0 gives posit 2.0, NaR (0x80000000)
  // in either operand raises inf, otherwise a plain integer sum.
  function automatic logic [31:0] f_res(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h48000000;
    return a + b;
  endfunction
  function automatic logic f_inf(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h80000000) || (b == 32'h80000000);
  endfunction
  function automatic logic f_zero(input logic [31:0] a, input logic [31:0] b);
    return !f_inf(a, b) && (f_res(a, b) == 32'h0);
  endfunction

  // Adder pipeline; deliberately never reset, like the real one.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pa [LAT];
  logic [31:0]    pb [LAT];
  logic           spur = 1'b0;

  initial for (int i = 0; i < LAT; i++) begin pa[i] = 32'h0; pb[i] = 32'h0; end

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], add_start};
    pa[0] <= add_in1;
    pb[0] <= add_in2;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end

  assign add_done   = pv[LAT-1] | spur;
  assign add_result = spur ? 32'hDEADBEEF : f_res(pa[LAT-1], pb[LAT-1]);
  assign add_inf    = spur ? 1'b0 : f_inf(pa[LAT-1], pb[LAT-1]);
  assign add_zero   = spur ? 1'b0 : f_zero(pa[LAT-1], pb[LAT-1]);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  // Reference model: an ordered list of accepted requests, each visible at
  // accept_cycle+LAT+1, plus a count of clock edges since reset release.
  typedef struct packed {
    logic [31:0] d;
    logic        inf;
    logic        zero;
    int          vis;
  } ent_t;

  ent_t q[$];
  int   mcyc = 0;
  int   edges = 0;
  logic m_err = 1'b0;
  int   m_si = 0, m_sz = 0;
  logic mon_en = 1'b0;
  int   pop_cnt = 0, first_pop = 0, last_pop = 0;
  logic stale_en = 1'b0;
  int   stale_cnt = 0;

  always @(negedge clk) begin
    logic er, ev;
    int   infl;
    ent_t e;
    if (stale_en && add_done) stale_cnt++;
    if (!reset_n) begin
      q.delete();
      edges = 0;
      m_err = 1'b0;
      m_si  = 0;
      m_sz  = 0;
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_add_start", add_start, 0);
      chk("rst_err",       err,       0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_flags", {out_inf, out_zero}, 0);
    end else begin
      er = (edges >= LAT + 1) && (q.size() < DEPTH);
      ev = (q.size() > 0) && (q[0].vis <= mcyc);
      chk("in_ready",  in_ready,  er);
      chk("add_start", add_start, in_valid && er);
      chk("add_in1",   add_in1,   in_a);
      chk("add_in2",   add_in2,   in_b);
      chk("out_valid", out_valid, ev);
      if (ev) begin
        chk("out_data", out_data, q[0].d);
        chk("out_inf",  out_inf,  q[0].inf);
        chk("out_zero", out_zero, q[0].zero);
      end
      chk("err", err, m_err);
`ifdef POSITADD_ISSUE_STREAM_STATS_EN
      chk("stat_inf_cnt",  stat_inf_cnt,  m_si);
      chk("stat_zero_cnt", stat_zero_cnt, m_sz);
`endif
      infl = 0;
      foreach (q[i]) if ((q[i].vis - LAT <= mcyc) && (mcyc <= q[i].vis - 1)) infl++;
      if (add_done && (edges >= LAT + 1) && infl == 0) m_err = 1'b1;
      if (mon_en && out_valid && out_ready) begin
        if (pop_cnt == 0) first_pop = mcyc;
        last_pop = mcyc;
        pop_cnt++;
      end
      if (ev && out_ready) begin
        if (q[0].inf  && m_si < 65535) m_si++;
        if (q[0].zero && m_sz < 65535) m_sz++;
        void'(q.pop_front());
      end
      if (in_valid && er) begin
        e.d    = f_res(in_a, in_b);
        e.inf  = f_inf(in_a, in_b);
        e.zero = f_zero(in_a, in_b);
        e.vis  = mcyc + LAT + 1;
        q.push_back(e);
      end
      edges++;
    end
    mcyc++;
  end

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_in_ready",  in_ready,  0);
    repeat (n) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Edges counted from release until in_ready is seen high.
  task automatic wait_ready(output int k);
    k = 0;
    while (k < 50) begin
      @(posedge clk); #1;
      k++;
      if (in_ready) break;
    end
  endtask

  initial begin
    int k, t0, acc, guard;

    do_reset(3);
    wait_ready(k);
    chk("drain_len", k, 9);

    // single pair
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000;
    t0 = tcyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("single_latency", tcyc - t0, 9);
    chk("single_data", out_data, 32'h48000000);
    chk("single_inf",  out_inf,  0);
    chk("single_zero", out_zero, 0);
    repeat (3) @(posedge clk); #1;

    // full throughput
    pop_cnt = 0;
    mon_en  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_a = 32'(i * 3 + 1);
      in_b = 32'(i * 256 + 7);
      chk("thru_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (LAT + 5) @(posedge clk); #1;
    mon_en = 1'b0;
    chk("thru_count",   pop_cnt, 32);
    chk("thru_gapless", last_pop - first_pop, 31);

    // backpressure
    out_ready = 1'b0;
    acc = 0;
    repeat (30) begin
      in_valid = 1'b1;
      in_a = 32'(100 + acc);
      in_b = 32'h0;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepts",   acc, 16);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_valid",     out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    repeat (4) begin
      in_a = 32'h55;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_one_more", acc, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk); #1;

    // spurious done
    chk("spur_err_before", err, 0);
    chk("spur_empty",      out_valid, 0);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    chk("spur_err_set",   err, 1);
    chk("spur_fifo_same", out_valid, 0);
    repeat (3) @(posedge clk); #1;
    chk("spur_err_sticky", err, 1);

    // reset mid-stream: 2 results landed, 5 still in flight
    do_reset(1);
    wait_ready(k);
    chk("drain_len2", k, 9);
    chk("err_cleared", err, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_a = 32'(i + 1);
      in_b = 32'(i + 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    chk("mid_valid_before", out_valid, 1);
    stale_cnt = 0;
    stale_en  = 1'b1;
    do_reset(1);
    chk("mid_valid_after", out_valid, 0);
    out_ready = 1'b1;
    wait_ready(k);
    chk("mid_drain_len", k, 9);
    repeat (10) @(posedge clk); #1;
    stale_en = 1'b0;
    chk("mid_stale_dones", stale_cnt, 5);
    chk("mid_err", err, 0);
    chk("mid_empty", out_valid, 0);

    // inf / zero results
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      case (i)
        0: begin in_a = 32'h80000000; in_b = 32'h1;        end
        1: begin in_a = 32'h80000000; in_b = 32'h2;        end
        2: begin in_a = 32'h3;        in_b = 32'h80000000; end
        3: begin in_a = 32'h5;        in_b = 32'hFFFFFFFB; end
        4: begin in_a = 32'h7;        in_b = 32'hFFFFFFF9; end
        default: begin in_a = 32'h1;  in_b = 32'h2;        end
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (LAT + 6) @(posedge clk); #1;
    chk("flags_empty", out_valid, 0);
`ifdef POSITADD_ISSUE_STREAM_STATS_EN
    chk("stat_inf_final",  stat_inf_cnt,  3);
    chk("stat_zero_final", stat_zero_cnt, 2);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
